// File: rtl/spi_transaction_sequencer.sv
// Burst sequencer for the byte-level spi_controller: TX/RX FIFOs, chip-select framing and per-byte triggering.
// Optional per-byte watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_transaction_sequencer #(
  parameter int FIFO_DEPTH      = 8,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_we,
  input  logic [7:0] tx_data,
  input  logic       rx_re,
  output logic [7:0] rx_data,
  input  logic       start,
  output logic       busy,
  output logic [7:0] status,
  input  logic       clear_flags,
  output logic       spi_trigger,
  output logic [7:0] spi_command,
  input  logic [7:0] spi_response,
  input  logic       spi_done,
  output logic       spi_cs
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]       SETUP_LAST = 4'(CS_SETUP_CYCLES - 1);
  localparam logic [3:0]       HOLD_LAST  = 4'(CS_HOLD_CYCLES - 1);

  // Elaboration-time parameter range checks.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (CS_SETUP_CYCLES < 1 || CS_SETUP_CYCLES > 15 || CS_HOLD_CYCLES < 1 || CS_HOLD_CYCLES > 15) begin : g_bad_cs
    $error("CS_SETUP_CYCLES and CS_HOLD_CYCLES must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_CS_HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] phase_count;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [CNT_W-1:0] tx_count;
  logic             tx_empty, tx_full, tx_push, tx_pop, tx_flush;
  logic             tx_overflow, tx_ovf_set;
  logic [7:0]       issue_byte;

  assign tx_empty   = (tx_count == '0);
  assign tx_full    = (tx_count == DEPTH_C);
  assign tx_pop     = (state_q == ST_ISSUE) && !tx_empty;
  assign tx_push    = tx_we && !tx_flush && (!tx_full || tx_pop);
  assign tx_ovf_set = tx_we && tx_full && !tx_pop;
  // A byte pushed into an empty FIFO on the cycle we enter ISSUE is forwarded directly.
  assign issue_byte = tx_empty ? tx_data : tx_mem[tx_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_rd_ptr <= tx_wr_ptr;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_W'(1);
        2'b01:   tx_count <= tx_count - CNT_W'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; occupancy counters alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [CNT_W-1:0] rx_count;
  logic             rx_empty, rx_full, rx_push_req, rx_push, rx_pop;
  logic             rx_overflow, rx_ovf_set;

  assign rx_empty    = (rx_count == '0);
  assign rx_full     = (rx_count == DEPTH_C);
  assign rx_push_req = (state_q == ST_WAIT) && spi_done;
  assign rx_pop      = rx_re && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovf_set  = rx_push_req && !rx_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= spi_response;
  end

  assign rx_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  // ---------------------------------------------------------------- watchdog
  logic timeout_hit;
  logic timeout_flag;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_count;

  // Counts cycles spent in WAIT; any other state rearms it for the next byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_count <= '0;
    end else if (state_q == ST_WAIT) begin
      wd_count <= wd_count + WD_W'(1);
    end else begin
      wd_count <= '0;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && !spi_done && (wd_count == WD_LAST);
  assign tx_flush    = timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_flag <= 1'b0;
    end else if (clear_flags) begin
      timeout_flag <= 1'b0;
    end else if (timeout_hit) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign tx_flush     = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // ---------------------------------------------------------------- sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
    end else if (clear_flags) begin
      tx_overflow <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (tx_ovf_set) tx_overflow <= 1'b1;
      if (rx_ovf_set) rx_overflow <= 1'b1;
    end
  end

  assign status = {1'b0, timeout_flag, rx_overflow, tx_overflow,
                   rx_full, rx_empty, tx_full, tx_empty};

  // ---------------------------------------------------------------- sequencer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (start && !tx_empty) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (phase_count == SETUP_LAST) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT;
      ST_WAIT: begin
        // A byte pushed in the same cycle as spi_done still joins this frame.
        if (spi_done)         state_d = (!tx_empty || tx_we) ? ST_ISSUE : ST_CS_HOLD;
        else if (timeout_hit) state_d = ST_CS_HOLD;
      end
      ST_CS_HOLD:  if (phase_count == HOLD_LAST) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_count <= '0;
    end else if ((state_q == ST_CS_SETUP || state_q == ST_CS_HOLD) && state_d == state_q) begin
      phase_count <= phase_count + 4'd1;
    end else begin
      phase_count <= '0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cs      <= 1'b1;
      busy        <= 1'b0;
      spi_trigger <= 1'b0;
      spi_command <= 8'h00;
    end else begin
      spi_cs      <= (state_d == ST_IDLE);
      busy        <= (state_d != ST_IDLE);
      spi_trigger <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) spi_command <= issue_byte;
    end
  end

endmodule

// File: doc/spi_transaction_sequencer.md
Name: spi_transaction_sequencer

Overview:
- Sequences multi-byte SPI bursts on the existing byte-level SPI controller, so the LSU no longer polls per byte and the core stalls less.
- The CPU pushes command bytes into a TX FIFO and pulses start. The block drives chip-select framing, issues one trigger per byte, and collects response bytes into an RX FIFO.
- Sits between the load/store unit's memory-mapped SPI registers and spi_controller, in the controller's clock domain.

Parameters:
- FIFO_DEPTH, 8: entries in each of the TX and RX FIFOs; power of two, 2..16.
- CS_SETUP_CYCLES, 2: cycles spi_cs is held low before the first trigger; range 1..15.
- CS_HOLD_CYCLES, 2: cycles spi_cs stays low after the last response before release; range 1..15.
- TIMEOUT_CYCLES, 256: maximum wait for spi_done per byte; used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  block clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tx_we  in  1  push tx_data into the TX FIFO.
- tx_data  in  8  command byte.
- rx_re  in  1  pop the RX FIFO head.
- rx_data  out  8  RX FIFO head; 0 when empty.
- start  in  1  begin a burst, sampled when idle.
- busy  out  1  high whenever state is not IDLE.
- status  out  8  [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_overflow, [5] rx_overflow, [6] timeout, [7] reserved 0.
- clear_flags  in  1  clears status[6:4].
- spi_trigger  out  1  one-cycle start pulse to spi_controller.
- spi_command  out  8  byte to shift out; registered.
- spi_response  in  8  byte shifted in; valid when spi_done is high.
- spi_done  in  1  one-cycle byte-complete pulse from spi_controller.
- spi_cs  out  1  chip select, active low.

Behaviour:
- Reset (async, rst=1): state IDLE; both FIFOs empty; all flags 0; spi_cs=1, spi_trigger=0, spi_command=0, busy=0, rx_data=0. Reset mid-burst aborts immediately and spi_cs goes to 1 asynchronously.
- States: IDLE, CS_SETUP, ISSUE, WAIT, CS_HOLD.
- IDLE:
  - start=1 with the TX FIFO non-empty moves to CS_SETUP and drives spi_cs=0 from the next cycle.
  - start with the TX FIFO empty is ignored.
  - start while busy is ignored.
- CS_SETUP: a counter runs for exactly CS_SETUP_CYCLES cycles, then moves to ISSUE.
- ISSUE (one cycle):
  - spi_trigger=1.
  - spi_command is loaded from the TX head and held until the next ISSUE.
  - The TX FIFO pops.
  - Next state is WAIT.
- WAIT:
  - On spi_done=1, spi_response is pushed into the RX FIFO and is visible on rx_data the next cycle if the FIFO was empty.
  - Next state is ISSUE if the TX FIFO is non-empty after this cycle's push, otherwise CS_HOLD.
  - A spi_done outside WAIT is ignored.
- CS_HOLD: runs for exactly CS_HOLD_CYCLES cycles, then IDLE with spi_cs=1. From that same cycle, busy=0.
- Burst latency for N bytes, with the controller taking T cycles from trigger to done: the first trigger occurs CS_SETUP_CYCLES+1 cycles after start is sampled. Each byte then costs T+1 cycles.
- TX FIFO:
  - A push while full is dropped and sets tx_overflow (sticky).
  - A push and a pop in the same cycle both take effect and the count is unchanged, including when full.
  - The CPU may append bytes mid-burst; they are sent in the same CS frame if they are pushed before WAIT exits.
- RX FIFO:
  - A response arriving while full is dropped and sets rx_overflow (sticky); the burst continues.
  - rx_re while empty is ignored.
  - rx_re and a response push in the same cycle both take effect.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. Occupancy counts are log2(FIFO_DEPTH)+1 bits.
- clear_flags has priority over a same-cycle flag set. Flags remain clear that cycle.
- All outputs are registered, except rx_data and status, which are combinational from registered state.

Optional Feature:
- Macro SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT.
  - If spi_done is not seen within TIMEOUT_CYCLES cycles, the timeout flag is set (sticky), the TX FIFO is flushed, and the state moves to CS_HOLD.
  - The counter restarts on every WAIT entry.
- Undefined:
  - No counter is built; WAIT lasts indefinitely.
  - status[6] is tied to 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- Single byte: push 0x9F, start; controller model with T=8 returns 0xEF. Expect:
  - spi_cs low 2 cycles before the trigger.
  - spi_command=0x9F.
  - rx_data=0xEF.
  - spi_cs high 2 cycles after spi_done.
  - busy low on that same cycle.
- Four-byte burst: push 0x03,0x00,0x10,0x00, start. Expect:
  - four triggers inside one continuous spi_cs-low window.
  - RX holds the model's echoes in order.
  - total busy time 2+4×9+2 = 40 cycles.
- FIFO boundaries:
  - Push 9 bytes while idle: 9th dropped, tx_overflow=1, tx_full=1.
  - Burst 9 bytes without RX reads: 9th response dropped, rx_overflow=1.
  - clear_flags restores status[5:4]=0.
- Ignored starts: start with TX empty leaves spi_cs=1 and busy=0. Start pulsed during a burst does not restart it or repeat a byte.
- Reset mid-burst: assert rst during WAIT of byte 2. Expect:
  - spi_cs=1 and spi_trigger=0 immediately.
  - FIFOs empty and status=0x05 after release.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16: model never returns done. Expect:
  - after 16 WAIT cycles, timeout=1 and tx_empty=1.
  - spi_cs released after CS_HOLD.
  - Without the macro, the block stays busy indefinitely.
